irq_ctrl: RTL and testbench

- Interrupt controller on the responder side of the CPU interrupt interface. It drives irq_take and irq_vector and consumes int_en and iret_detected.
- Collects NSRC external interrupt lines, then synchronises and rising-edge-detects each one.
- Latches each detected edge as pending, applies a mask and a fixed priority, then issues one taken interrupt at a time. The block stays busy until the handler returns.
- Exposes a small memory-mapped register set on the CPU data bus for mask, pending and status control.

---
 rtl/irq_ctrl_pkg.sv | 25 ++
 rtl/irq_sync_edge.sv | 36 +++
 rtl/irq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants and types for the interrupt controller
//
// Purpose: register offsets, FSM state encoding and STAT bit positions used
//          by irq_ctrl. No ports.

package irq_ctrl_pkg;

   // Byte offsets from BASE (bit 0 is never decoded)
   localparam logic [2:0] REG_PEND = 3'd0;
   localparam logic [2:0] REG_MASK = 3'd2;
   localparam logic [2:0] REG_STAT = 3'd4;
   localparam logic [2:0] REG_SWI  = 3'd6;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // STAT layout
   localparam int STAT_ACTIVE_BIT = 15;
   localparam int STAT_ID_LSB     = 0;
   localparam int STAT_ID_W       = 3;
   localparam int STAT_ELIG_LSB   = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchroniser plus rising-edge detector
//
// Purpose: brings one asynchronous request line into the clk domain and
//          produces a single-cycle pulse for each rising edge.
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-high reset
//   src  in   asynchronous request line
//   rise out  one-cycle pulse, sync2 & ~prev

module irq_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic src,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= src;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise = sync2 & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - prioritised interrupt controller with memory-mapped registers
//
// Purpose: latches rising edges of NSRC request lines as pending, masks them,
//          picks the lowest-numbered eligible source and hands one interrupt
//          at a time to the CPU, staying busy until the handler returns.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   irq_src[NSRC]      asynchronous request lines
//   int_en             CPU may take an interrupt this cycle
//   iret_detected      CPU is executing iret
//   irq_take           combinational take pulse
//   irq_vector[16]     handler address (VEC_BASE when no take)
//   d_ad[16]           CPU byte address
//   sw, lw             word store / load strobes
//   wdata[16]          store data
//   rdata[16]          read data, 0 when not selected
//   rsel               lw addressing this block

module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int          NSRC       = 8,
   parameter logic [15:0] BASE       = 16'hFF40,
   parameter logic [15:0] VEC_BASE   = 16'h0010,
   parameter logic [15:0] VEC_STRIDE = 16'h0004
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_src,
   input  logic            int_en,
   input  logic            iret_detected,
   output logic            irq_take,
   output logic [15:0]     irq_vector,
   input  logic [15:0]     d_ad,
   input  logic            sw,
   input  logic            lw,
   input  logic [15:0]     wdata,
   output logic [15:0]     rdata,
   output logic            rsel
);

   state_t          state;
   state_t          state_nxt;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] eligible;
   logic [NSRC-1:0] set_bits;
   logic [NSRC-1:0] clr_bits;
   logic [NSRC-1:0] take_bit;
   logic [2:0]      active_id;
   logic [2:0]      sel_id;
   logic [15:0]     off;
   logic            hit;
   logic            wr_pend;
   logic            wr_mask;
   logic            wr_swi;
   logic [15:0]     stat;
   logic [15:0]     elig_pad;
   logic            unused_bits;

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      irq_sync_edge u_sync (
         .clk  (clk),
         .rst  (rst),
         .src  (irq_src[i]),
         .rise (rise[i])
      );
   end

   // Subtracting BASE lets the decode work for any word-aligned BASE
   assign off     = d_ad - BASE;
   assign hit     = (off[15:3] == 13'd0);
   assign wr_pend = sw & hit & (off[2:1] == REG_PEND[2:1]);
   assign wr_mask = sw & hit & (off[2:1] == REG_MASK[2:1]);
   assign wr_swi  = sw & hit & (off[2:1] == REG_SWI[2:1]);

   assign eligible = pending & mask;

   // Lowest index wins: scanning downward lets the last hit overwrite
   always_comb begin
      sel_id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) sel_id = 3'(i);
      end
   end

   always_comb begin
      state_nxt  = state;
      irq_take   = 1'b0;
      irq_vector = VEC_BASE;
      case (state)
         IDLE: begin
            if (int_en && (|eligible)) begin
               irq_take   = 1'b1;
               irq_vector = VEC_BASE + 16'(sel_id) * VEC_STRIDE;
               state_nxt  = ACTIVE;
            end
         end
         ACTIVE: begin
            if (iret_detected) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      take_bit = '0;
      for (int i = 0; i < NSRC; i++) begin
         take_bit[i] = irq_take && (sel_id == 3'(i));
      end
   end

   // Sets are applied after clears so a same-cycle set always survives
   assign set_bits = rise | (wr_swi ? wdata[NSRC-1:0] : '0);
   assign clr_bits = take_bit | (wr_pend ? wdata[NSRC-1:0] : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pending   <= '0;
         mask      <= '0;
         active_id <= '0;
      end else begin
         state   <= state_nxt;
         pending <= (pending & ~clr_bits) | set_bits;
         if (wr_mask) mask <= wdata[NSRC-1:0];
         if (irq_take) active_id <= sel_id;
      end
   end

   // Eligible bits occupy STAT[NSRC+2:8], clipped below the ACTIVE bit
   assign elig_pad = 16'(eligible);

   always_comb begin
      stat = '0;
      stat[STAT_ACTIVE_BIT] = (state == ACTIVE);
      stat[STAT_ID_LSB +: STAT_ID_W] = active_id;
      for (int b = STAT_ELIG_LSB; b < STAT_ACTIVE_BIT; b++) begin
         if (b <= NSRC + 2) stat[b] = elig_pad[b - STAT_ELIG_LSB];
      end
   end

   assign rsel = lw & hit & ~rst;

   always_comb begin
      rdata = '0;
      if (rsel) begin
         case (off[2:1])
            REG_PEND[2:1]: rdata = 16'(pending);
            REG_MASK[2:1]: rdata = 16'(mask);
            REG_STAT[2:1]: rdata = stat;
            default:       rdata = '0;
         endcase
      end
   end

   assign unused_bits = ^{off[0], wdata};

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl

module tb_irq_ctrl;

   localparam logic [15:0] A_PEND = 16'hFF40;
   localparam logic [15:0] A_MASK = 16'hFF42;
   localparam logic [15:0] A_STAT = 16'hFF44;
   localparam logic [15:0] A_SWI  = 16'hFF46;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq_src;
   logic        int_en;
   logic        iret_detected;
   logic        irq_take;
   logic [15:0] irq_vector;
   logic [15:0] d_ad;
   logic        sw;
   logic        lw;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        rsel;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   irq_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .irq_src       (irq_src),
      .int_en        (int_en),
      .iret_detected (iret_detected),
      .irq_take      (irq_take),
      .irq_vector    (irq_vector),
      .d_ad          (d_ad),
      .sw            (sw),
      .lw            (lw),
      .wdata         (wdata),
      .rdata         (rdata),
      .rsel          (rsel)
   );

   typedef struct {
      bit          is_wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] exp;
      bit          exp_rsel;
   } vec_t;

   vec_t tbl[14];

   // reference model state
   logic [7:0]  m_pend, m_mask, h0, h1, h2, elig, setb, clrb;
   bit          m_active, e_take, e_rsel;
   int          m_id, sel, ntake, first, nwait;
   logic [15:0] e_vec, e_rd, rv, vtake;
   bit          rs, got;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      d_ad = a; wdata = d; sw = 1'b1;
      cyc;
      sw = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] v, output bit s);
      d_ad = a; lw = 1'b1;
      #1;
      v = rdata; s = rsel;
      lw = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1; irq_src = '0; int_en = 1'b0; iret_detected = 1'b0;
      sw = 1'b0; lw = 1'b0; d_ad = '0; wdata = '0;
      cyc; cyc;
      rst = 1'b0;
      m_pend = '0; m_mask = '0; m_active = 1'b0; m_id = 0;
      h0 = '0; h1 = '0; h2 = '0;
   endtask

   task automatic wait_take(input int limit, output bit g, output logic [15:0] v, output int n);
      g = 1'b0; v = '0; n = -1;
      for (int i = 0; i <= limit; i++) begin
         #1;
         if (irq_take) begin
            g = 1'b1; v = irq_vector; n = i;
            break;
         end
         cyc;
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, A_MASK,       16'h00FF, 16'h0000, 1'b0};
      tbl[1]  = '{1'b0, A_MASK,       16'h0000, 16'h00FF, 1'b1};
      tbl[2]  = '{1'b1, A_MASK,       16'h02A5, 16'h0000, 1'b0};
      tbl[3]  = '{1'b0, A_MASK + 1,   16'h0000, 16'h00A5, 1'b1};
      tbl[4]  = '{1'b1, A_SWI,        16'h0010, 16'h0000, 1'b0};
      tbl[5]  = '{1'b0, A_PEND,       16'h0000, 16'h0010, 1'b1};
      tbl[6]  = '{1'b0, A_SWI,        16'h0000, 16'h0000, 1'b1};
      tbl[7]  = '{1'b1, A_PEND,       16'h0010, 16'h0000, 1'b0};
      tbl[8]  = '{1'b0, A_PEND,       16'h0000, 16'h0000, 1'b1};
      tbl[9]  = '{1'b1, A_SWI,        16'h0005, 16'h0000, 1'b0};
      tbl[10] = '{1'b0, A_STAT,       16'h0000, 16'h0500, 1'b1};
      tbl[11] = '{1'b0, 16'hFF48,     16'h0000, 16'h0000, 1'b0};
      tbl[12] = '{1'b1, A_PEND,       16'h00FF, 16'h0000, 1'b0};
      tbl[13] = '{1'b0, A_PEND,       16'h0000, 16'h0000, 1'b1};

      // reset state
      rst = 1'b1; irq_src = '0; int_en = 1'b1; iret_detected = 1'b0;
      sw = 1'b0; lw = 1'b1; d_ad = A_PEND; wdata = '0;
      #3;
      chk("rst_take", irq_take, 0);
      chk("rst_rsel", rsel, 0);
      chk("rst_rdata", rdata, 0);
      do_reset;
      rd(A_MASK, rv, rs); chk("rst_mask", rv, 0);
      rd(A_PEND, rv, rs); chk("rst_pend", rv, 0);
      rd(A_STAT, rv, rs); chk("rst_stat", rv, 0);

      // register table
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
         else begin
            rd(tbl[i].addr, rv, rs);
            chk($sformatf("tbl%0d_rdata", i), rv, tbl[i].exp);
            chk($sformatf("tbl%0d_rsel", i), rs, tbl[i].exp_rsel);
         end
      end

      // store held across a stall
      wr(A_MASK, 16'h0000);
      d_ad = A_MASK; wdata = 16'h00FF; sw = 1'b1;
      repeat (4) cyc;
      sw = 1'b0;
      rd(A_MASK, rv, rs); chk("held_mask", rv, 16'h00FF);

      // basic take
      do_reset;
      wr(A_MASK, 16'h0001);
      int_en = 1'b1; irq_src = 8'h01; ntake = 0; first = -1; vtake = '0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (irq_take) begin
            ntake++;
            if (first < 0) first = i;
            vtake = irq_vector;
         end
         cyc;
         irq_src = '0;
      end
      chk("basic_count", ntake, 1);
      chk("basic_vec", vtake, 16'h0010);
      chk("basic_latency", first, 3);
      rd(A_STAT, rv, rs); chk("basic_stat", rv, 16'h8000);
      iret_detected = 1'b1; cyc; iret_detected = 1'b0;

      // priority, masking, busy lockout
      do_reset;
      wr(A_MASK, 16'h0006);
      int_en = 1'b1; irq_src = 8'h07;
      wait_take(10, got, vtake, nwait);
      chk("prio_first_got", got, 1);
      chk("prio_first_vec", vtake, 16'h0014);
      cyc; irq_src = '0;
      iret_detected = 1'b1; #1;
      chk("prio_ret_notake", irq_take, 0);
      cyc; iret_detected = 1'b0;
      wait_take(10, got, vtake, nwait);
      chk("prio_second_vec", vtake, 16'h0018);
      chk("prio_second_wait", nwait, 0);
      cyc;
      wr(A_MASK, 16'h000E);
      wr(A_SWI, 16'h0008);
      ntake = 0;
      for (int i = 0; i < 5; i++) begin
         #1; if (irq_take) ntake++;
         cyc;
      end
      chk("busy_notake", ntake, 0);
      rd(A_STAT, rv, rs); chk("busy_stat", rv, 16'h8002);
      iret_detected = 1'b1; #1;
      chk("busy_ret_notake", irq_take, 0);
      cyc; iret_detected = 1'b0; #1;
      chk("busy_after_take", irq_take, 1);
      chk("busy_after_vec", irq_vector, 16'h001C);
      cyc;
      iret_detected = 1'b1; cyc; iret_detected = 1'b0;
      ntake = 0;
      for (int i = 0; i < 10; i++) begin
         #1; if (irq_take) ntake++;
         cyc;
      end
      chk("masked_never", ntake, 0);
      rd(A_PEND, rv, rs); chk("masked_pend", rv, 16'h0001);

      // int_en gating
      int_en = 1'b0;
      wr(A_MASK, 16'h0010);
      wr(A_SWI, 16'h0010);
      ntake = 0;
      for (int i = 0; i < 10; i++) begin
         #1; if (irq_take) ntake++;
         cyc;
      end
      chk("inten_off", ntake, 0);
      int_en = 1'b1; #1;
      chk("inten_on_take", irq_take, 1);
      chk("inten_on_vec", irq_vector, 16'h0020);
      cyc; iret_detected = 1'b1; cyc; iret_detected = 1'b0; int_en = 1'b0;

      // W1C colliding with an edge, level sets once
      wr(A_MASK, 16'h0000);
      wr(A_SWI, 16'h0020);
      irq_src = 8'h20;
      cyc; cyc;
      d_ad = A_PEND; wdata = 16'h0020; sw = 1'b1;
      cyc; sw = 1'b0;
      rd(A_PEND, rv, rs); chk("w1c_vs_edge", rv, 16'h0021);
      wr(A_PEND, 16'h0020);
      cyc; cyc;
      rd(A_PEND, rv, rs); chk("level_once", rv, 16'h0001);
      irq_src = '0;

      // async reset mid-handler
      wr(A_MASK, 16'h0001);
      wr(A_SWI, 16'h0001);
      int_en = 1'b1; #1;
      chk("arst_pre_take", irq_take, 1);
      cyc;
      #1 rst = 1'b1;
      #1;
      chk("arst_take", irq_take, 0);
      lw = 1'b1; d_ad = A_STAT; #1;
      chk("arst_rsel", rsel, 0);
      lw = 1'b0;
      rst = 1'b0;
      rd(A_STAT, rv, rs); chk("arst_stat", rv, 0);
      rd(A_MASK, rv, rs); chk("arst_mask", rv, 0);
      int_en = 1'b0;
      cyc;

      // randomized run against the reference model
      do_reset;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom % 4 == 0) irq_src = 8'($urandom);
         int_en = ($urandom % 4) != 0;
         iret_detected = ($urandom % 5) == 0;
         sw = 1'b0; lw = 1'b0; wdata = 16'($urandom);
         case ($urandom % 8)
            0: begin sw = 1'b1; d_ad = A_MASK; end
            1: begin sw = 1'b1; d_ad = A_SWI; wdata = wdata & 16'($urandom); end
            2: begin sw = 1'b1; d_ad = A_PEND; end
            3, 4: begin lw = 1'b1; d_ad = A_PEND + 16'(2 * ($urandom % 5)); end
            default: d_ad = 16'h0000;
         endcase
         #1;
         elig = m_pend & m_mask;
         e_take = !m_active && int_en && (elig != 0);
         sel = 0;
         for (int i = 7; i >= 0; i--) if (elig[i]) sel = i;
         e_vec = e_take ? 16'h0010 + 16'(sel * 4) : 16'h0010;
         chk("rnd_take", irq_take, e_take);
         chk("rnd_vec", irq_vector, e_vec);
         if (lw) begin
            e_rsel = 1'b1;
            case (d_ad)
               A_PEND: e_rd = {8'h00, m_pend};
               A_MASK: e_rd = {8'h00, m_mask};
               A_STAT: e_rd = {m_active, 4'b0, elig[2:0], 5'b0, 3'(m_id)};
               A_SWI:  e_rd = 16'h0000;
               default: begin e_rd = 16'h0000; e_rsel = 1'b0; end
            endcase
            chk("rnd_rdata", rdata, e_rd);
            chk("rnd_rsel", rsel, e_rsel);
         end
         setb = (h1 & ~h2) | ((sw && d_ad == A_SWI) ? wdata[7:0] : 8'h00);
         clrb = (e_take ? 8'(1 << sel) : 8'h00) | ((sw && d_ad == A_PEND) ? wdata[7:0] : 8'h00);
         m_pend = (m_pend & ~clrb) | setb;
         if (sw && d_ad == A_MASK) m_mask = wdata[7:0];
         if (e_take) begin
            m_active = 1'b1; m_id = sel;
         end else if (m_active && iret_detected) m_active = 1'b0;
         h2 = h1; h1 = h0; h0 = irq_src;
         cyc;
      end
      sw = 1'b0; lw = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
